serial_pattern_detector: RTL
============================

Name: serial_pattern_detector

Overview:
Parametrised serial bit-stream pattern detector, the next generation of our fixed 4-bit detect/stop FSMs. It matches a runtime-programmable PAT_W-bit pattern and locks up when a programmable STOP_W-bit stop pattern appears. It adds a qualified input strobe, overlap/non-overlap mode, synchronous clear and a match counter. It sits behind serial receive front-ends and flags frame markers to downstream control.

Parameters:
PAT_W, 4, match pattern length in bits (1..32)
STOP_W, 4, stop pattern length in bits (1..32)
CNT_W, 8, match counter width (>=1)
OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, PAT_W fresh bits are required before the next match

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  synchronous clear of history, fill counts, stopped and match_count
bit_valid  input  1  qualifies bit_in this cycle
bit_in  input  1  serial data bit
match_pat  input  PAT_W  pattern; MSB = oldest bit received
stop_pat  input  STOP_W  stop pattern; MSB = oldest bit received
stop_en  input  1  enables stop-pattern detection
detected  output  1  one-cycle pulse per match
stopped  output  1  sticky lock indicator
match_count  output  CNT_W  number of matches since reset/clear

Behaviour:
- One clock, reset is asynchronous and active-low: rst_n low immediately forces detected=0, stopped=0, match_count=0, history=0, both fill counts=0.
- History: shift register of max(PAT_W,STOP_W) bits. On an edge with bit_valid=1, clear=0 and stopped=0, bit_in shifts in at the LSB.
- Fill counts: mfill saturates at PAT_W and sfill saturates at STOP_W. Each increments per accepted bit. This prevents false matches of all-zero patterns out of reset.
- Match condition, evaluated on the updated history: mfill==PAT_W and low PAT_W history bits == match_pat.
- Stop condition, evaluated on the updated history: stop_en=1, sfill==STOP_W and low STOP_W history bits == stop_pat.
- Latency: detected and stopped are registered.
  - A bit sampled at edge N that completes a match drives detected=1 from edge N to edge N+1.
  - On that same edge N, match_count increments.
- detected is 0 on every cycle without a new completing bit, including bit_valid=0 cycles.
- OVERLAP=0: on a match, mfill resets to 0; sfill is unaffected. OVERLAP=1: mfill stays saturated.
- Stop priority: if one bit completes both match and stop, stopped=1, detected=0 and match_count is unchanged.
- Lock state: while stopped=1, all bits are ignored, detected stays 0 and match_count holds. Only clear or rst_n exits the lock.
- clear=1 takes effect at the edge: history, mfill, sfill, stopped and match_count go to 0; detected=0 next cycle. A bit presented in the same cycle as clear is discarded (clear wins).
- Pattern inputs are sampled each edge. A change applies to the next accepted bit; no retroactive match is made on the existing history.
- Counter: default CNT_W-bit wrap-around, so all-ones + 1 = 0.

Optional Feature:
Macro SERIAL_PATTERN_DETECTOR_CNT_SAT_EN.
- Defined: match_count saturates at all-ones; further matches still pulse detected.
- Undefined: match_count wraps modulo 2^CNT_W.

Test Plan:
- Defaults, match_pat=1101, stop_en=0, bits 1,1,0,1 -> detected pulses once on the 4th bit; match_count=1.
- OVERLAP=1, bits 1,1,0,1,1,0,1 -> pulses on bits 4 and 7, count=2. OVERLAP=0, bits 1,1,0,1,1,0,1,1 -> pulse on bit 4 only, count=1. OVERLAP=0, bits 1,1,0,1,1,1,0,1 -> pulses on bits 4 and 8.
- stop_pat=1000, stop_en=1, bits 1,0,0,0 then 1,1,0,1 -> stopped=1 after bit 4; no further detect; count=0. Then clear=1 for one cycle -> stopped=0; bits 1,1,0,1 -> detect.
- match_pat=0000 after reset, bits 0,0,0 -> no detect; 4th 0 -> detect. Bits separated by bit_valid=0 gaps -> same result.
- CNT_W=2, 4 matches -> with macro, count=3; without macro, count=0. Also, clear asserted together with a completing bit -> no detect, count=0.
- rst_n pulled low asynchronously mid-pattern (after bits 1,1,0) -> all outputs 0 before the next edge; after release, bit 1 alone does not detect.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
//
// Serial bit-stream pattern detector. Matches a runtime-programmable PAT_W-bit
// pattern against the most recent accepted bits and locks up (sticky) when a
// programmable STOP_W-bit stop pattern is seen while stop detection is enabled.
//
// Optional build macro: SERIAL_PATTERN_DETECTOR_CNT_SAT_EN
//   defined   -> match_count saturates at all-ones
//   undefined -> match_count wraps modulo 2^CNT_W
//
// Parameters:
//   PAT_W    match pattern length (1..32)
//   STOP_W   stop pattern length (1..32)
//   CNT_W    match counter width (>=1)
//   OVERLAP  1 = overlapping matches, 0 = PAT_W fresh bits needed after a match
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous clear of history, fill counts, lock and counter
//   bit_valid    qualifies bit_in
//   bit_in       serial data bit
//   match_pat    match pattern, MSB = oldest bit
//   stop_pat     stop pattern, MSB = oldest bit
//   stop_en      enables stop-pattern detection
//   detected     one-cycle registered pulse per match
//   stopped      sticky lock indicator (registered)
//   match_count  matches since reset/clear
module serial_pattern_detector #(
   parameter int unsigned PAT_W   = 4,
   parameter int unsigned STOP_W  = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned OVERLAP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic [PAT_W-1:0]  match_pat,
   input  logic [STOP_W-1:0] stop_pat,
   input  logic              stop_en,
   output logic              detected,
   output logic              stopped,
   output logic [CNT_W-1:0]  match_count
);

   localparam int unsigned HIST_W = (PAT_W > STOP_W) ? PAT_W : STOP_W;
   localparam int unsigned MF_W   = $clog2(PAT_W + 1);
   localparam int unsigned SF_W   = $clog2(STOP_W + 1);
   localparam logic [MF_W-1:0] MF_FULL = MF_W'(PAT_W);
   localparam logic [SF_W-1:0] SF_FULL = SF_W'(STOP_W);

   typedef enum logic [0:0] {StRun, StLock} state_t;

   state_t            state;
   logic [HIST_W-1:0] hist;
   logic [HIST_W-1:0] hist_nxt;
   logic [MF_W-1:0]   mfill;
   logic [MF_W-1:0]   mfill_nxt;
   logic [SF_W-1:0]   sfill;
   logic [SF_W-1:0]   sfill_nxt;
   logic [CNT_W-1:0]  count_nxt;
   logic              accept;
   logic              m_hit;
   logic              s_hit;

   // Candidate values assuming the current bit is accepted; conditions are
   // evaluated on the updated history so the completing bit is included.
   always_comb begin
      accept    = bit_valid && !clear && (state == StRun);
      hist_nxt  = (hist << 1) | HIST_W'(bit_in);
      mfill_nxt = (mfill == MF_FULL) ? mfill : mfill + 1'b1;
      sfill_nxt = (sfill == SF_FULL) ? sfill : sfill + 1'b1;
      // Fill counts gate the compare so all-zero patterns cannot match the
      // zeroed history out of reset or clear.
      m_hit     = (mfill_nxt == MF_FULL) && (hist_nxt[PAT_W-1:0] == match_pat);
      s_hit     = stop_en && (sfill_nxt == SF_FULL) && (hist_nxt[STOP_W-1:0] == stop_pat);
`ifdef SERIAL_PATTERN_DETECTOR_CNT_SAT_EN
      count_nxt = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + 1'b1;
`else
      count_nxt = match_count + 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StRun;
         hist        <= '0;
         mfill       <= '0;
         sfill       <= '0;
         detected    <= 1'b0;
         match_count <= '0;
      end else if (clear) begin
         state       <= StRun;
         hist        <= '0;
         mfill       <= '0;
         sfill       <= '0;
         detected    <= 1'b0;
         match_count <= '0;
      end else begin
         detected <= 1'b0;
         if (accept) begin
            hist  <= hist_nxt;
            sfill <= sfill_nxt;
            if (s_hit) begin
               // Stop wins over a simultaneous match.
               state <= StLock;
               mfill <= mfill_nxt;
            end else if (m_hit) begin
               detected    <= 1'b1;
               match_count <= count_nxt;
               mfill       <= (OVERLAP != 0) ? mfill_nxt : '0;
            end else begin
               mfill <= mfill_nxt;
            end
         end
      end
   end

   assign stopped = (state == StLock);

endmodule
